// File: rtl/m68k_bus_pkg.sv
// Shared encodings for the 68030 bus responder: size codes, function codes,
// DSACK encodings, FSM/cycle-kind enums and the captured request payload.
package m68k_bus_pkg;

    localparam logic [1:0] SZ_LONG  = 2'b00;
    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_3BYTE = 2'b11;

    localparam logic [2:0] FC_CPU = 3'b111;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_WAIT = 2'b11;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        KIND_MEM,
        KIND_BERR,
        KIND_IACK
    } kind_t;

    // Address-phase attributes latched at the start of a bus cycle
    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  fc;
        logic [1:0]  size;
        logic        rwn;
    } bus_req_t;

endpackage

// File: rtl/m68k_bus_responder_if.sv
// 68030 asynchronous bus bundle between the CPU (master) and a responder (slave).
interface m68k_bus_responder_if;

    logic [31:0] ADR;
    logic [31:0] DATA_WR;
    logic [2:0]  FC;
    logic [1:0]  SIZE;
    logic        RWn;
    logic        ASn;
    logic        DSn;
    logic [31:0] DATA_RD;
    logic [1:0]  DSACKn;
    logic        STERMn;
    logic        BERRn;
    logic        AVECn;

    modport master (
        output ADR, DATA_WR, FC, SIZE, RWn, ASn, DSn,
        input  DATA_RD, DSACKn, STERMn, BERRn, AVECn
    );

    modport slave (
        input  ADR, DATA_WR, FC, SIZE, RWn, ASn, DSn,
        output DATA_RD, DSACKn, STERMn, BERRn, AVECn
    );

endinterface

// File: rtl/m68k_lane_decode.sv
// Byte-lane enables from SIZE and A[1:0]; bit n enables lane n, lane0 = D[31:24].
module m68k_lane_decode
    import m68k_bus_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_a,
    output logic [3:0] o_lane_en_c
);

    logic [3:0] w_base;

    // Operand bytes starting at lane A, clipped at the 32-bit port edge
    always_comb begin
        w_base = 4'b1111;
        case (i_size)
            SZ_BYTE:  w_base = 4'b0001;
            SZ_WORD:  w_base = 4'b0011;
            SZ_3BYTE: w_base = 4'b0111;
            default:  w_base = 4'b1111;
        endcase
        o_lane_en_c = 4'(w_base << i_a);
    end

endmodule

// File: rtl/m68k_bus_responder.sv
// 32-bit-port memory responder for the 68030 bus with wait states,
// a bus-error address window and interrupt-acknowledge autovectoring.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          USE_STERM   = 1'b0,
    parameter logic [31:0] BERR_BASE   = 32'hFFF0_0000,
    parameter logic [31:0] BERR_MASK   = 32'hFFF0_0000
) (
    input logic                 CLK,
    input logic                 RESETn,
    m68k_bus_responder_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    bus_req_t             r_req;
    kind_t                w_kind;
    logic [ADDR_BITS-1:0] w_idx;
    logic [3:0]           w_lane_en;
    logic                 w_cap, w_mem_rd, w_mem_we;
    logic [1:0]           r_dsackn, w_dsackn_nxt;
    logic                 r_stermn, w_stermn_nxt;
    logic                 r_berrn, w_berrn_nxt;
    logic                 r_avecn, w_avecn_nxt;
    logic [31:0]          r_data_rd;
    logic [31:0]          r_mem [DEPTH];

    assign w_idx = r_req.adr[ADDR_BITS+1:2];

    m68k_lane_decode u_lane_decode (
        .i_size      (r_req.size),
        .i_a         (r_req.adr[1:0]),
        .o_lane_en_c (w_lane_en)
    );

    // Cycle classification, IACK taking priority over the CPU-space bus error
    always_comb begin
        w_kind = KIND_MEM;
        if (r_req.fc == FC_CPU && r_req.adr[19:16] == 4'hF) begin
            w_kind = KIND_IACK;
        end else if (r_req.fc == FC_CPU) begin
            w_kind = KIND_BERR;
        end else if ((r_req.adr & BERR_MASK) == BERR_BASE) begin
            w_kind = KIND_BERR;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cap        = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_we     = 1'b0;
        w_dsackn_nxt = r_dsackn;
        w_stermn_nxt = r_stermn;
        w_berrn_nxt  = r_berrn;
        w_avecn_nxt  = r_avecn;
        case (r_state)
            ST_IDLE: begin
                if (!bus.ASn) begin
                    w_cap       = 1'b1;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Writes must also see DSn before committing the data
                if (bus.ASn) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!(w_kind == KIND_MEM && !r_req.rwn && bus.DSn)) begin
                    w_state_nxt = ST_TERM;
                end
            end
            ST_TERM: begin
                case (w_kind)
                    KIND_MEM: begin
                        w_mem_rd = r_req.rwn;
                        w_mem_we = !r_req.rwn;
                        if (USE_STERM) w_stermn_nxt = 1'b0;
                        else           w_dsackn_nxt = DSACK_32;
                    end
                    KIND_BERR: w_berrn_nxt = 1'b0;
                    default:   w_avecn_nxt = 1'b0;
                endcase
                w_state_nxt = ST_HOLD;
            end
            default: begin
                w_stermn_nxt = 1'b1;
                if (bus.ASn) begin
                    w_dsackn_nxt = DSACK_WAIT;
                    w_berrn_nxt  = 1'b1;
                    w_avecn_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req     <= '0;
            r_dsackn  <= DSACK_WAIT;
            r_stermn  <= 1'b1;
            r_berrn   <= 1'b1;
            r_avecn   <= 1'b1;
            r_data_rd <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dsackn <= w_dsackn_nxt;
            r_stermn <= w_stermn_nxt;
            r_berrn  <= w_berrn_nxt;
            r_avecn  <= w_avecn_nxt;
            if (w_cap)    r_req     <= '{adr: bus.ADR, fc: bus.FC, size: bus.SIZE, rwn: bus.RWn};
            if (w_mem_rd) r_data_rd <= r_mem[w_idx];
        end
    end

    // Memory contents survive reset
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            if (w_lane_en[0]) r_mem[w_idx][31:24] <= bus.DATA_WR[31:24];
            if (w_lane_en[1]) r_mem[w_idx][23:16] <= bus.DATA_WR[23:16];
            if (w_lane_en[2]) r_mem[w_idx][15:8]  <= bus.DATA_WR[15:8];
            if (w_lane_en[3]) r_mem[w_idx][7:0]   <= bus.DATA_WR[7:0];
        end
    end

    assign bus.DATA_RD = r_data_rd;
    assign bus.DSACKn  = r_dsackn;
    assign bus.STERMn  = r_stermn;
    assign bus.BERRn   = r_berrn;
    assign bus.AVECn   = r_avecn;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: three instances (0/3/8 wait states,
// STERM on the middle one) share one stimulus set; each test observes one instance.
module tb_m68k_bus_responder;
    import m68k_bus_pkg::*;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    logic [31:0] t_adr, t_wd;
    logic [2:0]  t_fc;
    logic [1:0]  t_sz;
    logic        t_rwn, t_asn, t_dsn;

    logic [31:0] o_data   [3];
    logic [1:0]  o_dsackn [3];
    logic        o_stermn [3];
    logic        o_berrn  [3];
    logic        o_avecn  [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        m68k_bus_responder_if bus ();
        assign bus.ADR     = t_adr;
        assign bus.DATA_WR = t_wd;
        assign bus.FC      = t_fc;
        assign bus.SIZE    = t_sz;
        assign bus.RWn     = t_rwn;
        assign bus.ASn     = t_asn;
        assign bus.DSn     = t_dsn;
        assign o_data[g]   = bus.DATA_RD;
        assign o_dsackn[g] = bus.DSACKn;
        assign o_stermn[g] = bus.STERMn;
        assign o_berrn[g]  = bus.BERRn;
        assign o_avecn[g]  = bus.AVECn;

        m68k_bus_responder #(
            .ADDR_BITS   (10),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 8)),
            .USE_STERM   (g == 1),
            .BERR_BASE   (32'hFFF0_0000),
            .BERR_MASK   (32'hFFF0_0000)
        ) u_dut (
            .CLK    (CLK),
            .RESETn (RESETn),
            .bus    (bus)
        );
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic term_seen(input int sel);
        return (o_dsackn[sel] != 2'b11) || !o_stermn[sel] || !o_berrn[sel] || !o_avecn[sel];
    endfunction

    // Starts a cycle and returns k = edges after the first ASn-low sample until
    // the selected instance shows a termination (40 means it never did)
    task automatic run_cycle(input int sel, input logic [31:0] adr, input logic [2:0] fc,
                             input logic [1:0] sz, input logic rwn, input logic [31:0] wd,
                             input int dsn_delay, output int k);
        t_adr = adr; t_fc = fc; t_sz = sz; t_rwn = rwn; t_wd = wd;
        t_asn = 1'b0;
        t_dsn = (dsn_delay > 0);
        tick();
        k = 0;
        while (!term_seen(sel) && k < 40) begin
            if (k + 1 == dsn_delay) t_dsn = 1'b0;
            tick();
            k++;
        end
    endtask

    task automatic end_cycle();
        t_asn = 1'b1;
        t_dsn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        t_asn = 1'b1; t_dsn = 1'b1; t_rwn = 1'b1;
        t_adr = '0; t_wd = '0; t_fc = 3'd5; t_sz = SZ_LONG;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({o_dsackn[i], o_stermn[i], o_berrn[i], o_avecn[i]} !== 5'b11111) begin
                errors++;
                $display("FAIL reset_terms[%0d]: got %b want 11111", i,
                         {o_dsackn[i], o_stermn[i], o_berrn[i], o_avecn[i]});
            end
            checks++;
            if (o_data[i] !== 32'h0) begin
                errors++; $display("FAIL reset_data[%0d]: got %h want 0", i, o_data[i]);
            end
        end
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_long_rw();
        int k;
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b0, 32'hDEADBEEF, 0, k);
        checks++;
        if (k !== 2) begin errors++; $display("FAIL long_wr_lat: got %0d want 2", k); end
        checks++;
        if (o_dsackn[0] !== 2'b00) begin errors++; $display("FAIL long_wr_dsack: got %b want 00", o_dsackn[0]); end
        end_cycle();
        checks++;
        if (o_dsackn[0] !== 2'b11) begin errors++; $display("FAIL long_wr_release: got %b want 11", o_dsackn[0]); end
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (k !== 2) begin errors++; $display("FAIL long_rd_lat: got %0d want 2", k); end
        checks++;
        if (o_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL long_rd_data: got %h want deadbeef", o_data[0]); end
        end_cycle();
    endtask

    task automatic test_byte_word();
        int k;
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b0, 32'h11223344, 0, k);
        end_cycle();
        checks++;
        if (o_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold_thru_wr: got %h want deadbeef", o_data[0]); end
        run_cycle(0, 32'h103, 3'd5, SZ_BYTE, 1'b0, 32'hFFFFFF5A, 0, k);
        end_cycle();
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_data[0] !== 32'h1122335A) begin errors++; $display("FAIL byte_wr: got %h want 1122335a", o_data[0]); end
        end_cycle();
        run_cycle(0, 32'h101, 3'd5, SZ_WORD, 1'b0, 32'hFFA5A5FF, 0, k);
        end_cycle();
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_data[0] !== 32'h11A5A55A) begin errors++; $display("FAIL word_wr: got %h want 11a5a55a", o_data[0]); end
        end_cycle();
    endtask

    task automatic test_wrap();
        int k;
        run_cycle(0, 32'h0000_1100, 3'd5, SZ_LONG, 1'b0, 32'hCAFEF00D, 0, k);
        end_cycle();
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_data[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL addr_wrap: got %h want cafef00d", o_data[0]); end
        end_cycle();
    endtask

    task automatic test_sterm();
        int k;
        run_cycle(1, 32'h200, 3'd5, SZ_LONG, 1'b0, 32'h12345678, 0, k);
        checks++;
        if (k !== 5) begin errors++; $display("FAIL sterm_wr_lat: got %0d want 5", k); end
        end_cycle();
        run_cycle(1, 32'h200, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (k !== 5 || o_stermn[1] !== 1'b0) begin
            errors++; $display("FAIL sterm_rd_lat: got k=%0d sterm=%b want k=5 sterm=0", k, o_stermn[1]);
        end
        checks++;
        if (o_data[1] !== 32'h12345678) begin errors++; $display("FAIL sterm_rd_data: got %h want 12345678", o_data[1]); end
        tick();
        checks++;
        if (o_stermn[1] !== 1'b1 || o_dsackn[1] !== 2'b11) begin
            errors++; $display("FAIL sterm_one_clk: got sterm=%b dsack=%b want 1 11", o_stermn[1], o_dsackn[1]);
        end
        end_cycle();
    endtask

    task automatic test_berr();
        int k;
        run_cycle(0, 32'hFFF0_0010, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (k !== 2 || o_berrn[0] !== 1'b0 || o_dsackn[0] !== 2'b11) begin
            errors++; $display("FAIL berr_window: got k=%0d berr=%b dsack=%b want 2 0 11", k, o_berrn[0], o_dsackn[0]);
        end
        tick();
        checks++;
        if (o_berrn[0] !== 1'b0) begin errors++; $display("FAIL berr_hold: got %b want 0", o_berrn[0]); end
        end_cycle();
        checks++;
        if (o_berrn[0] !== 1'b1) begin errors++; $display("FAIL berr_release: got %b want 1", o_berrn[0]); end
        run_cycle(0, 32'h0002_0000, 3'd7, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_berrn[0] !== 1'b0 || o_dsackn[0] !== 2'b11 || o_avecn[0] !== 1'b1) begin
            errors++; $display("FAIL berr_cpu_space: got berr=%b dsack=%b avec=%b want 0 11 1", o_berrn[0], o_dsackn[0], o_avecn[0]);
        end
        end_cycle();
    endtask

    task automatic test_iack();
        int k;
        run_cycle(0, 32'h000F_FFFF, 3'd7, SZ_BYTE, 1'b1, 32'h0, 0, k);
        checks++;
        if (k !== 2 || o_avecn[0] !== 1'b0 || o_berrn[0] !== 1'b1) begin
            errors++; $display("FAIL iack_avec: got k=%0d avec=%b berr=%b want 2 0 1", k, o_avecn[0], o_berrn[0]);
        end
        tick();
        checks++;
        if (o_avecn[0] !== 1'b0) begin errors++; $display("FAIL iack_hold: got %b want 0", o_avecn[0]); end
        end_cycle();
        checks++;
        if (o_avecn[0] !== 1'b1) begin errors++; $display("FAIL iack_release: got %b want 1", o_avecn[0]); end
    endtask

    task automatic test_dsn_stall();
        int k;
        run_cycle(0, 32'h104, 3'd5, SZ_LONG, 1'b0, 32'h600DF00D, 4, k);
        checks++;
        if (k !== 5) begin errors++; $display("FAIL dsn_stall_lat: got %0d want 5", k); end
        end_cycle();
        run_cycle(0, 32'h104, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_data[0] !== 32'h600DF00D) begin errors++; $display("FAIL dsn_stall_data: got %h want 600df00d", o_data[0]); end
        end_cycle();
    endtask

    task automatic test_abort();
        int k;
        logic seen;
        run_cycle(2, 32'h300, 3'd5, SZ_LONG, 1'b0, 32'h0BADCAFE, 0, k);
        checks++;
        if (k !== 10) begin errors++; $display("FAIL ws8_lat: got %0d want 10", k); end
        end_cycle();
        t_adr = 32'h300; t_wd = 32'hFFFFFFFF; t_rwn = 1'b0; t_sz = SZ_LONG;
        t_asn = 1'b0; t_dsn = 1'b0;
        seen = 1'b0;
        repeat (4) begin tick(); if (term_seen(2)) seen = 1'b1; end
        t_asn = 1'b1; t_dsn = 1'b1;
        repeat (12) begin tick(); if (term_seen(2)) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_term: got %b want 0", seen); end
        run_cycle(2, 32'h300, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_data[2] !== 32'h0BADCAFE) begin errors++; $display("FAIL abort_mem: got %h want 0badcafe", o_data[2]); end
        end_cycle();
    endtask

    task automatic test_reset_mid();
        int k;
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (o_dsackn[0] !== 2'b00 || o_data[0] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL pre_reset: got %b %h want 00 cafef00d", o_dsackn[0], o_data[0]);
        end
        #2 RESETn = 1'b0;
        #1;
        checks++;
        if (o_dsackn[0] !== 2'b11 || o_data[0] !== 32'h0) begin
            errors++; $display("FAIL async_reset: got %b %h want 11 0", o_dsackn[0], o_data[0]);
        end
        t_asn = 1'b1;
        #2 RESETn = 1'b1;
        tick();
        run_cycle(0, 32'h100, 3'd5, SZ_LONG, 1'b1, 32'h0, 0, k);
        checks++;
        if (k !== 2 || o_data[0] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL post_reset_cycle: got k=%0d %h want 2 cafef00d", k, o_data[0]);
        end
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_long_rw();
        test_byte_word();
        test_wrap();
        test_sterm();
        test_berr();
        test_iack();
        test_dsn_stall();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Synchronous slave/responder for the 68030 asynchronous bus driven by the wf68k30L core: ADR, FC, SIZE, RWn, ASn, DSn in; DSACKn/STERMn/BERRn/AVECn and read data out.
- Contains a 32-bit-port word memory, programmable wait states, a bus-error window and interrupt-acknowledge autovectoring.
- Used as the memory model behind core and equivalence benches, replacing random DSACKn/STERMn stimulus with protocol-correct terminations.

Parameters:
- ADDR_BITS, 10, log2 of memory depth in 32-bit words
- WAIT_STATES, 0, clocks inserted before termination (0..15)
- USE_STERM, 0, 1 = terminate memory cycles with STERMn (one clock); 0 = DSACKn=2'b00
- BERR_BASE, 32'hFFF0_0000, bus-error window base
- BERR_MASK, 32'hFFF0_0000, address bits compared against BERR_BASE

Ports:
- CLK  in  1  bus clock; all inputs sampled on rising edge
- RESETn  in  1  asynchronous, active-low reset
- ADR  in  32  CPU ADR_OUT
- DATA_WR  in  32  CPU DATA_OUT
- FC  in  3  function code
- SIZE  in  2  01 byte, 10 word, 11 three-byte, 00 long
- RWn  in  1  1 read, 0 write
- ASn  in  1  address strobe
- DSn  in  1  data strobe
- DATA_RD  out  32  to CPU DATA_IN
- DSACKn  out  2  asynchronous termination, 32-bit port = 2'b00
- STERMn  out  1  synchronous termination
- BERRn  out  1  bus error
- AVECn  out  1  autovector request

Behaviour:
- Reset: DSACKn=2'b11, STERMn=1, BERRn=1, AVECn=1, DATA_RD=0, state IDLE, wait counter 0. Memory array is not reset. Assertion mid-cycle negates all terminations immediately (async).
- States: IDLE, WAIT, TERM, HOLD.
- IDLE: on ASn sampled 0, capture ADR/FC/SIZE/RWn, set cnt=WAIT_STATES, go WAIT.
- Decode of captured values, in priority order:
  - FC=3'b111 and ADR[19:16]=4'hF: kind IACK.
  - Any other FC=7: kind BERR.
  - (ADR & BERR_MASK)==BERR_BASE: kind BERR.
  - Otherwise: kind MEM.
- WAIT:
  - If cnt!=0, decrement.
  - Else go TERM, except a MEM write also requires DSn sampled 0 (stall while DSn=1).
- TERM entry edge:
  - MEM read: DATA_RD <= mem[ADR[ADDR_BITS+1:2]].
  - MEM write: lane-enabled write of DATA_WR.
  - Assert the termination: MEM gives STERMn=0 if USE_STERM, else DSACKn=00; BERR gives BERRn=0; IACK gives AVECn=0.
- Latency: ASn first sampled 0 at edge N → termination visible after edge N+2+WAIT_STATES, provided DSn is already low for writes.
- TERM/HOLD:
  - STERMn lasts exactly one clock, then HOLD.
  - DSACKn/BERRn/AVECn stay asserted until ASn is sampled 1; negate on that same edge, then IDLE.
  - HOLD → IDLE on ASn sampled 1.
- Abort: ASn sampled 1 in WAIT → IDLE. No write, no termination.
- Back-to-back cycles: ASn must be seen 1 for at least one edge between cycles; a new cycle starts only from IDLE.
- Address wrap: word index = ADR[ADDR_BITS+1:2]; upper bits ignored except in the BERR/IACK decode.
- Lane numbering: lane0=D[31:24] (offset 0, big-endian) … lane3=D[7:0].
- Write lane enables by SIZE and A[1:0]:
  - byte: {A}.
  - word: 00→0,1; 01→1,2; 10→2,3; 11→3.
  - three-byte: 00→0,1,2; 01→1,2,3; 10→2,3; 11→3.
  - long: 00→all; 01→1,2,3; 10→2,3; 11→3.
- Data placement: write data is taken from the same lane positions (the CPU aligns operands). Reads always return the full word.
- DATA_RD holds its last read value through writes and idle.

Decomposition:
- Package m68k_bus_pkg:
  - SIZE codes (SZ_LONG/SZ_BYTE/SZ_WORD/SZ_3BYTE)
  - FC_CPU=3'b111
  - DSACK_32/DSACK_16/DSACK_8/DSACK_WAIT encodings
  - responder state enum
  - cycle-kind enum (MEM/BERR/IACK)
- Sub-module m68k_lane_decode: combinational SIZE+A[1:0] → 4-bit lane enable; reused later by a 16/8-bit port variant.

Test Plan:
- Long write then read of 32'hDEADBEEF at ADR 32'h100, WAIT_STATES=0 → DSACKn=00 two clocks after ASn is sampled low; read DATA_RD=32'hDEADBEEF.
- Byte write 8'h5A at ADR 32'h103 over a word holding 32'h11223344, followed by a long read → 32'h1122335A. Word write 16'hA5A5 at 32'h101 → 32'h11A5A55A.
- WAIT_STATES=3, USE_STERM=1 read → STERMn low for exactly one clock, 5 clocks after first ASn-low sample; DSACKn stays 11.
- Read at 32'hFFF0_0010, and a separate FC=7 access with ADR[19:16]=4'h2 → BERRn=0, no DSACK; BERRn released on the edge ASn is sampled high.
- FC=7, ADR=32'h000F_FFFF (IACK) → AVECn=0 until ASn negates. A write with DSn held high for 4 clocks → no termination until DSn=0.
- ASn negated in WAIT with WAIT_STATES=8 → no termination and memory unchanged. RESETn pulsed low during TERM → all terminations 1 immediately, DATA_RD=0, state IDLE.
